// File: rtl/mem_burst_reader.sv
// Burst reader: walks a contiguous address block in a sync-read memory
// and streams the words out through a 2-entry valid/ready buffer.
// Optional dataLast output is enabled with BURST_READER_LAST_EN.
module mem_burst_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  memRdEn,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    input  logic                  dataReady
`ifdef BURST_READER_LAST_EN
    ,
    output logic                  dataLast
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [LEN_WIDTH-1:0]    remain;
    logic                    inflight;
    logic [DATA_WIDTH-1:0]   buf_q [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;
    logic [1:0]              count_nxt;
    logic                    pop;
    logic                    accept;

    // A read issued last cycle lands in the buffer this cycle, so
    // count_nxt is buffer occupancy plus reads in flight after this
    // cycle's handshake; keeping it below 2 makes overflow impossible.
    assign pop       = dataValid & dataReady;
    assign count_nxt = count + {1'b0, inflight} - {1'b0, pop};
    assign dataValid = (count != 2'd0);
    assign dataOut   = buf_q[rd_ptr];
    assign memAddr   = addr;
    assign accept    = (state == IDLE) & start;

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, read issue and status outputs
    always_comb begin
        state_nxt = state;
        memRdEn   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (length == '0) ? DONE : READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if (count_nxt < 2'd2) begin
                    memRdEn = 1'b1;
                    if (remain == LEN_WIDTH'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (count_nxt == 2'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/remaining counters and read-in-flight flag
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            addr     <= '0;
            remain   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= memRdEn;
            if (accept) begin
                addr   <= startAddr;
                remain <= length;
            end else if (memRdEn) begin
                addr   <= addr + ADDR_WIDTH'(1);
                remain <= remain - LEN_WIDTH'(1);
            end
        end
    end

    // Two-entry output buffer fed by returning read data
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            count <= count_nxt;
            if (inflight) begin
                buf_q[wr_ptr] <= memData;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

`ifdef BURST_READER_LAST_EN
    logic [LEN_WIDTH-1:0] out_rem;

    assign dataLast = dataValid & (out_rem == LEN_WIDTH'(1));

    // Words still to be handed out; the head is last when one remains
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_rem <= '0;
        end else if (accept) begin
            out_rem <= length;
        end else if (pop) begin
            out_rem <= out_rem - LEN_WIDTH'(1);
        end
    end
`endif

endmodule
